// File: rtl/pipeline_mem_arbiter.sv
// Single-port memory arbiter shared by the pipeline's instruction-fetch and data requesters.
// One access in flight at a time; data wins ties, with a bounded starvation window for fetch.
module pipeline_mem_arbiter #(
  parameter int unsigned MEM_LAT  = 2,
  parameter int unsigned FAIR_MAX = 4,
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned CntW  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int unsigned FairW = (FAIR_MAX > 0) ? $clog2(FAIR_MAX + 1) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [FairW-1:0] fair_q;
  logic             owner_data_q;

  logic fair_sat;
  logic fair_hit;
  logic pick_data;

  assign fair_sat  = (fair_q == FairW'(FAIR_MAX));
  // FAIR_MAX of zero disables the forced fetch grant entirely.
  assign fair_hit  = (FAIR_MAX > 0) && fair_sat;
  assign pick_data = d_req && !(if_req && fair_hit);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      fair_q       <= '0;
      owner_data_q <= 1'b0;
      if_rdata     <= '0;
      if_ready     <= 1'b0;
      d_rdata      <= '0;
      d_ready      <= 1'b0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      mem_en   <= 1'b0;
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (if_req || d_req) begin
            owner_data_q <= pick_data;
            // Request fields are latched here and presented during the issue cycle.
            mem_en   <= 1'b1;
            mem_we   <= pick_data && d_we;
            mem_addr <= pick_data ? d_addr : if_addr;
            if (pick_data) begin
              mem_wdata <= d_wdata;
            end
            if (pick_data && if_req) begin
              if (!fair_sat) begin
                fair_q <= fair_q + FairW'(1);
              end
            end else begin
              fair_q <= '0;
            end
            state_q <= StIssue;
          end
        end
        StIssue: begin
          cnt_q   <= CntW'(MEM_LAT - 1);
          state_q <= StWait;
        end
        StWait: begin
          if (cnt_q == '0) begin
            if (!mem_we) begin
              if (owner_data_q) begin
                d_rdata <= mem_rdata;
              end else begin
                if_rdata <= mem_rdata;
              end
            end
            if (owner_data_q) begin
              d_ready <= 1'b1;
            end else begin
              if_ready <= 1'b1;
            end
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StResp: begin
          // Requests are deliberately ignored here so a just-completed requester can drop req.
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// Bench for pipeline_mem_arbiter: two instances (MEM_LAT=2/FAIR_MAX=4 and MEM_LAT=1/FAIR_MAX=0),
// each with a memory device, a transaction-level reference model and a per-cycle compare.
module tb_pipeline_mem_arbiter;

  localparam int NI = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset     [NI];
  logic        if_req    [NI];
  logic [31:0] if_addr   [NI];
  logic [31:0] if_rdata  [NI];
  logic        if_ready  [NI];
  logic        d_req     [NI];
  logic        d_we      [NI];
  logic [31:0] d_addr    [NI];
  logic [31:0] d_wdata   [NI];
  logic [31:0] d_rdata   [NI];
  logic        d_ready   [NI];
  logic        mem_en    [NI];
  logic        mem_we    [NI];
  logic [31:0] mem_addr  [NI];
  logic [31:0] mem_wdata [NI];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] init_word(input int i);
    return (i == 1) ? 32'h2008_0001 : (32'hA5A5_0000 | 32'(i));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : 1;
    localparam int F = (g == 0) ? 4 : 0;

    logic [31:0] mem_rdata;

    pipeline_mem_arbiter #(
      .MEM_LAT (L),
      .FAIR_MAX(F),
      .AW      (32),
      .DW      (32)
    ) u_dut (
      .clk      (clk),
      .reset    (reset[g]),
      .if_req   (if_req[g]),
      .if_addr  (if_addr[g]),
      .if_rdata (if_rdata[g]),
      .if_ready (if_ready[g]),
      .d_req    (d_req[g]),
      .d_we     (d_we[g]),
      .d_addr   (d_addr[g]),
      .d_wdata  (d_wdata[g]),
      .d_rdata  (d_rdata[g]),
      .d_ready  (d_ready[g]),
      .mem_en   (mem_en[g]),
      .mem_we   (mem_we[g]),
      .mem_addr (mem_addr[g]),
      .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata)
    );

    // Memory device: data valid exactly L cycles after the strobe, garbage otherwise.
    initial begin : device
      logic [31:0] dmem [16];
      logic [31:0] pend_data;
      int          pend_cyc;
      int          cyc;
      for (int i = 0; i < 16; i++) dmem[i] = init_word(i);
      pend_cyc  = -1;
      cyc       = 0;
      pend_data = '0;
      mem_rdata = '0;
      forever begin
        @(posedge clk);
        #1;
        cyc++;
        mem_rdata = (cyc == pend_cyc) ? pend_data : $urandom;
        if (mem_en[g] === 1'b1) begin
          if (mem_we[g]) begin
            dmem[mem_addr[g][5:2]] = mem_wdata[g];
          end else begin
            pend_cyc  = cyc + L;
            pend_data = dmem[mem_addr[g][5:2]];
          end
        end
      end
    end

    // Reference model: an access granted in cycle N occupies cycles N+1 .. N+L+2.
    initial begin : model
      logic [31:0] rmem [16];
      logic [31:0] e_irdata, e_drdata, e_addr, e_wdata, a, wd, rv;
      logic        e_iready, e_dready, e_en, e_we, we, gd, busy, started;
      int          age, fair;
      for (int i = 0; i < 16; i++) rmem[i] = init_word(i);
      {e_irdata, e_drdata, e_addr, e_wdata, a, wd, rv} = '0;
      {e_iready, e_dready, e_en, e_we, we, gd, busy, started} = '0;
      age  = 0;
      fair = 0;
      forever begin
        @(negedge clk);
        if (started) begin
          check($sformatf("i%0d mem_en", g), 32'(mem_en[g]), 32'(e_en));
          check($sformatf("i%0d mem_we", g), 32'(mem_we[g]), 32'(e_we));
          check($sformatf("i%0d mem_addr", g), mem_addr[g], e_addr);
          check($sformatf("i%0d mem_wdata", g), mem_wdata[g], e_wdata);
          check($sformatf("i%0d if_ready", g), 32'(if_ready[g]), 32'(e_iready));
          check($sformatf("i%0d d_ready", g), 32'(d_ready[g]), 32'(e_dready));
          check($sformatf("i%0d if_rdata", g), if_rdata[g], e_irdata);
          check($sformatf("i%0d d_rdata", g), d_rdata[g], e_drdata);
        end
        if (reset[g] === 1'b1) begin
          started = 1'b1;
          busy    = 1'b0;
          fair    = 0;
          {e_irdata, e_drdata, e_addr, e_wdata} = '0;
          {e_iready, e_dready, e_en, e_we} = '0;
        end else if (started) begin
          e_en     = 1'b0;
          e_iready = 1'b0;
          e_dready = 1'b0;
          if (busy) begin
            age++;
            if (age == L + 3) busy = 1'b0;
          end else if (if_req[g] || d_req[g]) begin
            gd = d_req[g] && !(if_req[g] && F > 0 && fair == F);
            if (gd && if_req[g]) fair = (fair < F) ? fair + 1 : fair;
            else fair = 0;
            we = gd && d_we[g];
            a  = gd ? d_addr[g] : if_addr[g];
            wd = d_wdata[g];
            rv = rmem[a[5:2]];
            if (we) rmem[a[5:2]] = wd;
            busy = 1'b1;
            age  = 1;
          end
          if (busy && age == 1) begin
            e_en   = 1'b1;
            e_we   = we;
            e_addr = a;
            if (gd) e_wdata = wd;
          end
          if (busy && age == L + 2) begin
            if (gd) e_dready = 1'b1;
            else e_iready = 1'b1;
            if (!we) begin
              if (gd) e_drdata = rv;
              else e_irdata = rv;
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy(input int i, input bit dport, input int bound, output int k);
    bit seen;
    k    = 0;
    seen = 1'b0;
    while (!seen && k < bound) begin
      step();
      k++;
      seen = dport ? (d_ready[i] === 1'b1) : (if_ready[i] === 1'b1);
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL i%0d %s ready wait: none within %0d cycles, want one", i,
               dport ? "d" : "if", bound);
    end
  endtask

  task automatic rand_cycles(input int i, input int n);
    for (int c = 0; c < n; c++) begin
      step();
      reset[i] = ($urandom_range(149) == 0);
      if (if_ready[i]) if_req[i] = 1'b0;
      if (d_ready[i]) d_req[i] = 1'b0;
      if (!if_req[i] && $urandom_range(2) == 0) begin
        if_req[i]  = 1'b1;
        if_addr[i] = $urandom & 32'h0000_00FC;
      end
      if (!d_req[i] && $urandom_range(1) == 0) begin
        d_req[i]   = 1'b1;
        d_we[i]    = 1'($urandom_range(1));
        d_addr[i]  = $urandom & 32'h0000_00FC;
        d_wdata[i] = $urandom;
      end
    end
    step();
    reset[i]  = 1'b0;
    if_req[i] = 1'b0;
    d_req[i]  = 1'b0;
    step();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  initial begin : stim
    int   k, kd, ki, n, nd, ni;
    logic seq [10];
    for (int i = 0; i < NI; i++) begin
      reset[i]   = 1'b1;
      if_req[i]  = 1'b0;
      if_addr[i] = '0;
      d_req[i]   = 1'b0;
      d_we[i]    = 1'b0;
      d_addr[i]  = '0;
      d_wdata[i] = '0;
    end
    for (int i = 0; i < 10; i++) seq[i] = 1'bx;
    step();
    step();
    reset[0] = 1'b0;

    // Single fetch: strobe at N+1, ready at N+4.
    step();
    if_req[0]  = 1'b1;
    if_addr[0] = 32'h0000_0004;
    step();
    check("t1 mem_en at N+1", 32'(mem_en[0]), 32'd1);
    check("t1 mem_addr", mem_addr[0], 32'h0000_0004);
    wait_rdy(0, 1'b0, 20, k);
    check("t1 if_ready cycle", 32'(k + 1), 32'd4);
    check("t1 if_rdata", if_rdata[0], 32'h2008_0001);
    if_req[0] = 1'b0;

    // Simultaneous requests: data first, fetch follows.
    step();
    d_req[0]   = 1'b1;
    d_we[0]    = 1'b0;
    d_addr[0]  = 32'h0000_0100;
    if_req[0]  = 1'b1;
    if_addr[0] = 32'h0000_0008;
    kd = -1;
    ki = -1;
    for (int c = 1; c <= 30 && ki < 0; c++) begin
      step();
      if (d_ready[0]) begin
        kd = c;
        d_req[0] = 1'b0;
      end
      if (if_ready[0]) begin
        ki = c;
        if_req[0] = 1'b0;
      end
    end
    check("t2 d_ready cycle", 32'(kd), 32'd4);
    check("t2 if_ready cycle", 32'(ki), 32'd9);
    check("t2 d_rdata", d_rdata[0], 32'hA5A5_0000);
    check("t2 if_rdata", if_rdata[0], 32'hA5A5_0002);

    // Write then read back.
    step();
    d_req[0]   = 1'b1;
    d_we[0]    = 1'b1;
    d_addr[0]  = 32'h0000_0020;
    d_wdata[0] = 32'hDEAD_BEEF;
    step();
    check("t4 mem_en", 32'(mem_en[0]), 32'd1);
    check("t4 mem_we", 32'(mem_we[0]), 32'd1);
    check("t4 mem_addr", mem_addr[0], 32'h0000_0020);
    check("t4 mem_wdata", mem_wdata[0], 32'hDEAD_BEEF);
    wait_rdy(0, 1'b1, 20, k);
    check("t4 write ready cycle", 32'(k + 1), 32'd4);
    check("t4 d_rdata kept on write", d_rdata[0], 32'hA5A5_0000);
    d_we[0] = 1'b0;
    wait_rdy(0, 1'b1, 20, k);
    check("t4 back-to-back spacing", 32'(k), 32'd5);
    check("t4 read-back", d_rdata[0], 32'hDEAD_BEEF);
    d_req[0] = 1'b0;

    // Reset during WAIT aborts; held request is re-issued.
    step();
    d_req[0]  = 1'b1;
    d_we[0]   = 1'b0;
    d_addr[0] = 32'h0000_0044;
    step();
    step();
    reset[0] = 1'b1;
    step();
    check("t5 mem_en after reset", 32'(mem_en[0]), 32'd0);
    check("t5 mem_we after reset", 32'(mem_we[0]), 32'd0);
    check("t5 mem_addr after reset", mem_addr[0], 32'd0);
    check("t5 mem_wdata after reset", mem_wdata[0], 32'd0);
    check("t5 d_ready after reset", 32'(d_ready[0]), 32'd0);
    check("t5 if_ready after reset", 32'(if_ready[0]), 32'd0);
    check("t5 d_rdata after reset", d_rdata[0], 32'd0);
    check("t5 if_rdata after reset", if_rdata[0], 32'd0);
    reset[0] = 1'b0;
    wait_rdy(0, 1'b1, 20, k);
    check("t5 reissue ready cycle", 32'(k), 32'd4);
    check("t5 reissue d_rdata", d_rdata[0], 32'h2008_0001);
    d_req[0] = 1'b0;

    // Fairness: four data grants, then one fetch, repeating.
    step();
    reset[0] = 1'b1;
    step();
    reset[0]   = 1'b0;
    d_req[0]   = 1'b1;
    d_addr[0]  = 32'h0000_0010;
    if_req[0]  = 1'b1;
    if_addr[0] = 32'h0000_0014;
    n = 0;
    for (int c = 0; c < 200 && n < 10; c++) begin
      step();
      if (d_ready[0]) begin
        seq[n] = 1'b1;
        n++;
      end
      if (if_ready[0] && n < 10) begin
        seq[n] = 1'b0;
        n++;
      end
    end
    for (int i = 0; i < 10; i++)
      check($sformatf("t3 grant %0d is data", i), 32'(seq[i]), 32'((i % 5) != 4));
    d_req[0]  = 1'b0;
    if_req[0] = 1'b0;
    step();
    step();

    rand_cycles(0, 1500);
    reset[0] = 1'b1;

    // Second instance: MEM_LAT=1, strict data priority.
    reset[1] = 1'b0;
    step();
    d_req[1]  = 1'b1;
    d_we[1]   = 1'b0;
    d_addr[1] = 32'h0000_0004;
    step();
    check("t6 mem_en at N+1", 32'(mem_en[1]), 32'd1);
    wait_rdy(1, 1'b1, 20, k);
    check("t6 d_ready cycle", 32'(k + 1), 32'd3);
    check("t6 d_rdata", d_rdata[1], 32'h2008_0001);
    wait_rdy(1, 1'b1, 20, k);
    check("t6 turnaround", 32'(k), 32'd4);
    if_req[1]  = 1'b1;
    if_addr[1] = 32'h0000_0018;
    nd = 0;
    ni = 0;
    for (int c = 0; c < 60 && nd < 8; c++) begin
      step();
      if (d_ready[1]) nd++;
      if (if_ready[1]) ni++;
    end
    check("t3b data grants", 32'(nd), 32'd8);
    check("t3b fetch grants while data held", 32'(ni), 32'd0);
    d_req[1] = 1'b0;
    wait_rdy(1, 1'b0, 20, k);
    check("t3b fetch after data drops", 32'(k), 32'd4);
    if_req[1] = 1'b0;
    step();

    rand_cycles(1, 2000);

    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
